// File: rtl/dec_arb_pkg.sv
`default_nettype none
// ============================================================================
// Module   : dec_arb_pkg
// Brief    : Shared types, constants and round-robin pick for dec_rr_arb.
//            GUARD state exists only when DEC_ARB_GUARD_EN is defined.
// Revision : 1.0 - initial release
// ============================================================================
package dec_arb_pkg;

  localparam int NUM_REQ      = 8;
  localparam int SEL_W        = 3;
  localparam int HOLD_W       = 4;
  localparam int DEF_MAX_HOLD = 4;

`ifdef DEC_ARB_GUARD_EN
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1,
    ST_GUARD = 2'd2
  } state_t;
`else
  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_GRANT = 2'd1
  } state_t;
`endif

  // First set request scanning ptr, ptr+1, ... with 3-bit wrap.
  function automatic logic [SEL_W-1:0] rr_pick(input logic [NUM_REQ-1:0] req,
                                               input logic [SEL_W-1:0]   ptr);
    logic [SEL_W-1:0] idx;
    logic [SEL_W-1:0] cand;
    logic             found;
    idx   = '0;
    found = 1'b0;
    for (int i = 0; i < NUM_REQ; i++) begin
      cand = ptr + SEL_W'(i);
      if (!found && req[cand]) begin
        idx   = cand;
        found = 1'b1;
      end
    end
    return idx;
  endfunction

endpackage
`default_nettype wire

// File: rtl/dec3to8_l.sv
`default_nettype none
// ============================================================================
// Module   : dec3to8_l
// Brief    : 74x138-style 3-to-8 decoder with active-low outputs.
// Revision : 1.0 - initial release
// ============================================================================
module dec3to8_l
  import dec_arb_pkg::*;
(
  input  logic               g1,
  input  logic               g2a_l,
  input  logic               g2b_l,
  input  logic [SEL_W-1:0]   sel,
  output logic [NUM_REQ-1:0] cs_l
);

  logic w_en;

  assign w_en = g1 & ~g2a_l & ~g2b_l;
  assign cs_l = w_en ? ~(NUM_REQ'(1) << sel) : {NUM_REQ{1'b1}};

endmodule
`default_nettype wire

// File: rtl/dec_rr_arb.sv
`default_nettype none
// ============================================================================
// Module   : dec_rr_arb
// Brief    : Round-robin arbiter with hold limit driving a shared 3-to-8
//            decoder. Optional one-cycle GUARD via DEC_ARB_GUARD_EN.
// Revision : 1.0 - initial release
// ============================================================================
module dec_rr_arb
  import dec_arb_pkg::*;
#(
  parameter int MAX_HOLD = DEF_MAX_HOLD
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_REQ-1:0] req,
  output logic [SEL_W-1:0]   sel,
  output logic               g1,
  output logic               g2a_l,
  output logic               g2b_l,
  output logic [NUM_REQ-1:0] cs_l,
  output logic               gnt_vld
);

  state_t            r_state;
  state_t            w_state_nxt;
  logic [SEL_W-1:0]  r_ptr;
  logic [SEL_W-1:0]  w_ptr_nxt;
  logic [SEL_W-1:0]  r_sel;
  logic [SEL_W-1:0]  w_sel_nxt;
  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;
  logic [SEL_W-1:0]  w_ptr_rel;
  logic              w_release;
  logic              w_grant;

  assign w_ptr_rel = r_sel + SEL_W'(1);
  assign w_release = ~req[r_sel] | (r_hold == HOLD_W'(MAX_HOLD));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_ptr   <= '0;
      r_sel   <= '0;
      r_hold  <= '0;
    end else begin
      r_state <= w_state_nxt;
      r_ptr   <= w_ptr_nxt;
      r_sel   <= w_sel_nxt;
      r_hold  <= w_hold_nxt;
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    w_ptr_nxt   = r_ptr;
    w_sel_nxt   = r_sel;
    w_hold_nxt  = r_hold;
    case (r_state)
      ST_GRANT: begin
        if (w_release) begin
          w_ptr_nxt = w_ptr_rel;
`ifdef DEC_ARB_GUARD_EN
          w_state_nxt = ST_GUARD;
          w_hold_nxt  = '0;
`else
          // Back-to-back: re-arbitrate from the advanced pointer this cycle.
          if (|req) begin
            w_sel_nxt  = rr_pick(req, w_ptr_rel);
            w_hold_nxt = HOLD_W'(1);
          end else begin
            w_state_nxt = ST_IDLE;
            w_hold_nxt  = '0;
          end
`endif
        end else begin
          w_hold_nxt = r_hold + HOLD_W'(1);
        end
      end
      default: begin
        // IDLE and GUARD both arbitrate from the stored pointer.
        if (|req) begin
          w_state_nxt = ST_GRANT;
          w_sel_nxt   = rr_pick(req, r_ptr);
          w_hold_nxt  = HOLD_W'(1);
        end else begin
          w_state_nxt = ST_IDLE;
        end
      end
    endcase
  end

  assign w_grant = (r_state == ST_GRANT);
  assign g1      = w_grant;
  assign g2a_l   = ~w_grant;
  assign g2b_l   = ~w_grant;
  assign gnt_vld = w_grant;
  assign sel     = r_sel;

  dec3to8_l u_dec (
    .g1    (g1),
    .g2a_l (g2a_l),
    .g2b_l (g2b_l),
    .sel   (r_sel),
    .cs_l  (cs_l)
  );

endmodule
`default_nettype wire
